// File: rtl/pc_branch_unit.sv
// Program counter, flag latch and LUT-based branch resolution with start/halt control.
// Optional macro FLAG_BYPASS_EN lets a same-cycle compare feed its branch directly.
module pc_branch_unit #(
  parameter int                  PC_WIDTH   = 10,
  parameter int                  LUT_DEPTH  = 16,
  parameter int                  LUT_IDX_W  = 4,
  parameter logic [PC_WIDTH-1:0] START_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 halt,
  input  logic                 flagWrite,
  input  logic                 equal,
  input  logic                 lessThan,
  input  logic [1:0]           branchType,
  input  logic [LUT_IDX_W-1:0] branchIdx,
  input  logic                 lutWrite,
  input  logic [LUT_IDX_W-1:0] lutWrIdx,
  input  logic [PC_WIDTH-1:0]  lutWrData,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 fetchValid,
  output logic                 taken,
  output logic                 done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_LT   = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;

  logic [1:0]          r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic                r_eqFlag;
  logic                r_ltFlag;
  logic                r_taken;
  logic                r_done;
  logic [PC_WIDTH-1:0] r_lut [LUT_DEPTH];

  logic                w_eqSel;
  logic                w_ltSel;
  logic                w_branch;
  logic [PC_WIDTH-1:0] w_target;

`ifdef FLAG_BYPASS_EN
  assign w_eqSel = flagWrite ? equal    : r_eqFlag;
  assign w_ltSel = flagWrite ? lessThan : r_ltFlag;
`else
  assign w_eqSel = r_eqFlag;
  assign w_ltSel = r_ltFlag;
`endif

  // Read is from the pre-write array, so a same-index write returns the old target.
  assign w_target = r_lut[branchIdx];

  always_comb begin
    w_branch = 1'b0;
    case (branchType)
      BR_NONE: w_branch = 1'b0;
      BR_EQ:   w_branch = w_eqSel;
      BR_LT:   w_branch = w_ltSel;
      BR_JMP:  w_branch = 1'b1;
      default: w_branch = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        r_lut[i] <= '0;
      end
    end else if (lutWrite) begin
      r_lut[lutWrIdx] <= lutWrData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eqFlag <= 1'b0;
      r_ltFlag <= 1'b0;
    end else if ((r_state == S_RUN) && flagWrite) begin
      r_eqFlag <= equal;
      r_ltFlag <= lessThan;
    end
  end

  // Halt outranks any branch; taken only ever marks a LUT load into pc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= START_ADDR;
      r_taken <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_taken <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_pc    <= START_ADDR;
          end
        end
        S_RUN: begin
          if (halt) begin
            r_state <= S_HALTED;
            r_done  <= 1'b1;
          end else if (w_branch) begin
            r_pc    <= w_target;
            r_taken <= 1'b1;
          end else begin
            r_pc <= r_pc + PC_ONE;
          end
        end
        S_HALTED: begin
          if (start) begin
            r_state <= S_RUN;
            r_pc    <= START_ADDR;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_pc    <= START_ADDR;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign pc         = r_pc;
  assign fetchValid = (r_state == S_RUN);
  assign taken      = r_taken;
  assign done       = r_done;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: a behavioural program-counter model checked
// every cycle, plus hand-computed expectations along the directed test sequence.
module tb_pc_branch_unit;

  localparam int PCW    = 10;
  localparam int IDXW   = 4;
  localparam int DEPTH  = 16;
  localparam int START  = 0;
  localparam int PC_MOD = 1 << PCW;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_HALTED = 2;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            halt;
  logic            flagWrite;
  logic            equal;
  logic            lessThan;
  logic [1:0]      branchType;
  logic [IDXW-1:0] branchIdx;
  logic            lutWrite;
  logic [IDXW-1:0] lutWrIdx;
  logic [PCW-1:0]  lutWrData;
  logic [PCW-1:0]  pc;
  logic            fetchValid;
  logic            taken;
  logic            done;

  int vecCount  = 0;
  int missCount = 0;

  // Behavioural model state, initialised to the reset picture.
  int mState = M_IDLE;
  int mPc    = START;
  int mEq    = 0;
  int mLt    = 0;
  int mTaken = 0;
  int mDone  = 0;
  int mLut [DEPTH];

  pc_branch_unit #(
    .PC_WIDTH  (PCW),
    .LUT_DEPTH (DEPTH),
    .LUT_IDX_W (IDXW),
    .START_ADDR(PCW'(START))
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .halt      (halt),
    .flagWrite (flagWrite),
    .equal     (equal),
    .lessThan  (lessThan),
    .branchType(branchType),
    .branchIdx (branchIdx),
    .lutWrite  (lutWrite),
    .lutWrIdx  (lutWrIdx),
    .lutWrData (lutWrData),
    .pc        (pc),
    .fetchValid(fetchValid),
    .taken     (taken),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Branch decision from the rules: which flag values the instruction sees this cycle.
  function automatic int modelBranch();
    int eqSeen;
    int ltSeen;
    eqSeen = mEq;
    ltSeen = mLt;
`ifdef FLAG_BYPASS_EN
    if (flagWrite) begin
      eqSeen = int'(equal);
      ltSeen = int'(lessThan);
    end
`endif
    case (branchType)
      2'b01:   return eqSeen;
      2'b10:   return ltSeen;
      2'b11:   return 1;
      default: return 0;
    endcase
  endfunction

  // Model advance: all right-hand sides see the pre-edge values, as the hardware does.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mState <= M_IDLE;
      mPc    <= START;
      mEq    <= 0;
      mLt    <= 0;
      mTaken <= 0;
      mDone  <= 0;
      for (int i = 0; i < DEPTH; i++) mLut[i] <= 0;
    end else begin
      if (lutWrite) mLut[int'(lutWrIdx)] <= int'(lutWrData);
      mTaken <= 0;
      if (mState == M_IDLE) begin
        if (start) begin
          mState <= M_RUN;
          mPc    <= START;
        end
      end else if (mState == M_RUN) begin
        if (flagWrite) begin
          mEq <= int'(equal);
          mLt <= int'(lessThan);
        end
        if (halt) begin
          mState <= M_HALTED;
          mDone  <= 1;
        end else if (modelBranch() != 0) begin
          mPc    <= mLut[int'(branchIdx)];
          mTaken <= 1;
        end else begin
          mPc <= (mPc + 1) % PC_MOD;
        end
      end else begin
        if (start) begin
          mState <= M_RUN;
          mPc    <= START;
          mDone  <= 0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vecCount++;
    if (actual != expected) begin
      missCount++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    checkOutput("model.pc",         int'(pc),         mPc);
    checkOutput("model.fetchValid", int'(fetchValid), (mState == M_RUN) ? 1 : 0);
    checkOutput("model.taken",      int'(taken),      mTaken);
    checkOutput("model.done",       int'(done),       mDone);
  end

  task automatic expectNow(input string tag, input int pcExp, input int fvExp,
                           input int tkExp, input int dnExp);
    checkOutput({tag, ".pc"},         int'(pc),         pcExp);
    checkOutput({tag, ".fetchValid"}, int'(fetchValid), fvExp);
    checkOutput({tag, ".taken"},      int'(taken),      tkExp);
    checkOutput({tag, ".done"},       int'(done),       dnExp);
  endtask

  // Present one instruction's worth of inputs for a single clock, then idle them.
  task automatic applyStimulus(input logic st, input logic hl, input logic fw,
                               input logic eq, input logic lt,
                               input logic [1:0] bt, input logic [IDXW-1:0] bi);
    start      = st;
    halt       = hl;
    flagWrite  = fw;
    equal      = eq;
    lessThan   = lt;
    branchType = bt;
    branchIdx  = bi;
    @(posedge clk);
    #1;
    start      = 1'b0;
    halt       = 1'b0;
    flagWrite  = 1'b0;
    equal      = 1'b0;
    lessThan   = 1'b0;
    branchType = 2'b00;
    branchIdx  = '0;
  endtask

  task automatic stepPlain();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
  endtask

  task automatic lutLoad(input logic [IDXW-1:0] idx, input logic [PCW-1:0] data);
    lutWrite  = 1'b1;
    lutWrIdx  = idx;
    lutWrData = data;
    stepPlain();
    lutWrite  = 1'b0;
    lutWrIdx  = '0;
    lutWrData = '0;
  endtask

  initial begin
    rst_n      = 1'b1;
    start      = 1'b0;
    halt       = 1'b0;
    flagWrite  = 1'b0;
    equal      = 1'b0;
    lessThan   = 1'b0;
    branchType = 2'b00;
    branchIdx  = '0;
    lutWrite   = 1'b0;
    lutWrIdx   = '0;
    lutWrData  = '0;
    for (int i = 0; i < DEPTH; i++) mLut[i] = 0;

    #2 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;
    expectNow("reset", 0, 0, 0, 0);

    $display("[TB] sequential fetch after start");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
    expectNow("start", 0, 1, 0, 0);
    stepPlain(); expectNow("seq1", 1, 1, 0, 0);
    stepPlain(); expectNow("seq2", 2, 1, 0, 0);
    stepPlain(); expectNow("seq3", 3, 1, 0, 0);

    $display("[TB] branch-if-equal taken and not taken");
    lutLoad(4'd3, 10'h040);
    expectNow("lutWr", 4, 1, 0, 0);
    stepPlain();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 4'd0);
    expectNow("cmpEq", 6, 1, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'd3);
    expectNow("beqTaken", 'h040, 1, 1, 0);
    stepPlain(); expectNow("afterTaken", 'h041, 1, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'd3);
    expectNow("beqNotTaken", 'h043, 1, 0, 0);

    $display("[TB] same-cycle compare and branch");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 4'd3);
`ifdef FLAG_BYPASS_EN
    expectNow("sameCycle", 'h040, 1, 1, 0);
`else
    expectNow("sameCycle", 'h044, 1, 0, 0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'd3);
    expectNow("bltTaken", 'h040, 1, 1, 0);

    $display("[TB] pc wrap at top of address space");
    lutLoad(4'd5, 10'h3FE);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'd5);
    expectNow("jmpTop", 'h3FE, 1, 1, 0);
    stepPlain(); expectNow("top", 'h3FF, 1, 0, 0);
    stepPlain(); expectNow("wrap", 0, 1, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
    expectNow("startInRun", 1, 1, 0, 0);

    $display("[TB] halt beats jump, restart from halted");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 4'd5);
    expectNow("halt", 1, 0, 0, 1);
    stepPlain(); expectNow("halted", 1, 0, 0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
    expectNow("restart", 0, 1, 0, 0);

    $display("[TB] asynchronous reset mid-run");
    lutLoad(4'd6, 10'h010);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'd6);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 4'd0);
    stepPlain();
    expectNow("preReset", 'h012, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1 expectNow("asyncReset", 0, 0, 0, 0);
    #3 rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 4'd6);
    expectNow("idleIgnores", 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
    expectNow("postResetStart", 0, 1, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'd6);
    expectNow("eqCleared", 1, 1, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'd6);
    expectNow("ltCleared", 2, 1, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'd6);
    expectNow("lutCleared", 0, 1, 1, 0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
